// File: rtl/csr_trap_pkg.sv
// Shared types and constants for the MEM-stage trap sequencer.
// Exception codes, FSM encoding and the selected-trap bundle.
package csr_trap_pkg;

  localparam int TRAP_ECODE_W = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRAP  = 2'd1,
    DRAIN = 2'd2
  } trap_state_t;

  localparam logic [6:0] EC_INT  = 7'h00;
  localparam logic [6:0] EC_ADEF = 7'h08;
  localparam logic [6:0] EC_ALE  = 7'h09;
  localparam logic [6:0] EC_SYS  = 7'h0B;
  localparam logic [6:0] EC_BRK  = 7'h0C;
  localparam logic [6:0] EC_INE  = 7'h0D;
  localparam logic [6:0] EC_IPE  = 7'h0E;

  typedef struct packed {
    logic [TRAP_ECODE_W-1:0] ecode;
    logic [31:0]             badv;
    logic                    badv_we;
    logic [31:0]             era;
    logic                    is_int;
    logic                    is_ertn;
  } trap_req_t;

endpackage

// File: rtl/csr_trap_sequencer_sel.sv
// Combinational priority select among interrupt, A/B exceptions
// and ertn; also produces the B write-back kill.
import csr_trap_pkg::*;

module trap_priority_sel #(
  parameter int ECODE_INT = 0
) (
  input  logic                    idle,
  input  logic                    a_valid,
  input  logic                    b_valid,
  input  logic                    a_exc,
  input  logic                    b_exc,
  input  logic [TRAP_ECODE_W-1:0] a_ecode,
  input  logic [TRAP_ECODE_W-1:0] b_ecode,
  input  logic                    a_badv_we,
  input  logic                    b_badv_we,
  input  logic [31:0]             a_badv,
  input  logic [31:0]             b_badv,
  input  logic [31:0]             a_pc,
  input  logic [31:0]             b_pc,
  input  logic                    b_ertn,
  input  logic                    int_req,
  input  logic                    int_pending,
  output trap_req_t               req,
  output logic                    req_valid,
  output logic                    kill_b
);

  logic any_int;
  logic a_trap;
  logic int_hit;
  logic a_hit;
  logic b_hit;
  logic ertn_hit;

  // One-hot hit terms; lower priorities are masked by higher ones
  always_comb begin
    any_int  = int_req | int_pending;
    a_trap   = a_valid & a_exc;
    int_hit  = any_int & (a_valid | b_valid);
    a_hit    = ~int_hit & a_trap;
    b_hit    = ~int_hit & ~a_trap & b_valid & b_exc;
    ertn_hit = ~int_hit & ~a_trap & b_valid & b_ertn & ~b_exc;
  end

  // Build the trap bundle for the winning source
  always_comb begin
    req = '0;
    unique case (1'b1)
      int_hit: begin
        req.ecode  = TRAP_ECODE_W'(ECODE_INT);
        req.era    = a_valid ? a_pc : b_pc;
        req.is_int = 1'b1;
      end
      a_hit: begin
        req.ecode   = a_ecode;
        req.badv    = a_badv;
        req.badv_we = a_badv_we;
        req.era     = a_pc;
      end
      b_hit: begin
        req.ecode   = b_ecode;
        req.badv    = b_badv;
        req.badv_we = b_badv_we;
        req.era     = b_pc;
      end
      ertn_hit: begin
        req.is_ertn = 1'b1;
      end
      default: req = '0;
    endcase
  end

  // Inputs only matter while the sequencer is idle
  always_comb begin
    req_valid = idle & (int_hit | a_hit | b_hit | ertn_hit);
    kill_b    = idle & a_valid & (a_exc | any_int);
  end

endmodule

// File: rtl/csr_trap_sequencer.sv
// MEM-stage trap sequencer: captures one trap, emits the CSR
// commit and flush for a cycle, then drains before re-arming.
import csr_trap_pkg::*;

module csr_trap_sequencer #(
  parameter int ECODE_W   = 7,
  parameter int DRAIN_CYC = 2,
  parameter int ECODE_INT = 0
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               stall,
  input  logic               mem_a_valid,
  input  logic               mem_b_valid,
  input  logic               mem_a_exc,
  input  logic               mem_b_exc,
  input  logic [ECODE_W-1:0] mem_a_ecode,
  input  logic [ECODE_W-1:0] mem_b_ecode,
  input  logic               mem_a_badv_we,
  input  logic               mem_b_badv_we,
  input  logic [31:0]        mem_a_badv,
  input  logic [31:0]        mem_b_badv,
  input  logic [31:0]        mem_a_pc,
  input  logic [31:0]        mem_b_pc,
  input  logic               mem_b_ertn,
  input  logic               int_req,
  input  logic [31:0]        csr_eentry,
  input  logic [31:0]        csr_era,
  output logic               kill_b,
  output logic [ECODE_W-1:0] trap_ecode,
  output logic               trap_ecode_we,
  output logic [31:0]        trap_badv,
  output logic               trap_badv_we,
  output logic [31:0]        trap_era,
  output logic               trap_era_we,
  output logic               store_state,
  output logic               restore_state,
  output logic               flush,
  output logic [31:0]        flush_pc,
  output logic               int_pending,
  output logic               busy
);

  trap_state_t state;
  trap_state_t state_nxt;
  logic [2:0]  drain_cnt;
  logic        idle;
  logic        cap;
  logic        req_valid;
  trap_req_t   req;

  trap_priority_sel #(
    .ECODE_INT (ECODE_INT)
  ) u_sel (
    .idle        (idle),
    .a_valid     (mem_a_valid),
    .b_valid     (mem_b_valid),
    .a_exc       (mem_a_exc),
    .b_exc       (mem_b_exc),
    .a_ecode     (TRAP_ECODE_W'(mem_a_ecode)),
    .b_ecode     (TRAP_ECODE_W'(mem_b_ecode)),
    .a_badv_we   (mem_a_badv_we),
    .b_badv_we   (mem_b_badv_we),
    .a_badv      (mem_a_badv),
    .b_badv      (mem_b_badv),
    .a_pc        (mem_a_pc),
    .b_pc        (mem_b_pc),
    .b_ertn      (mem_b_ertn),
    .int_req     (int_req),
    .int_pending (int_pending),
    .req         (req),
    .req_valid   (req_valid),
    .kill_b      (kill_b)
  );

  assign cap = req_valid & ~stall;

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state: stall never holds TRAP or DRAIN
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (cap) state_nxt = TRAP;
      TRAP:    state_nxt = DRAIN;
      DRAIN:   if (drain_cnt == 3'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    idle = (state == IDLE);
    busy = ~idle;
  end

  // Drain counter, loaded on leaving TRAP
  always_ff @(posedge clk) begin
    if (!rstn)
      drain_cnt <= 3'd0;
    else if (state == TRAP)
      drain_cnt <= 3'(DRAIN_CYC - 1);
    else if (state == DRAIN && drain_cnt != 3'd0)
      drain_cnt <= drain_cnt - 3'd1;
  end

  // Sticky interrupt request, dropped only when taken
  always_ff @(posedge clk) begin
    if (!rstn)
      int_pending <= 1'b0;
    else if (cap & req.is_int)
      int_pending <= 1'b0;
    else if (int_req)
      int_pending <= 1'b1;
  end

  // One-cycle trap commit toward the MEM->WB CSR register
  always_ff @(posedge clk) begin
    if (!rstn || !cap) begin
      trap_ecode    <= '0;
      trap_ecode_we <= 1'b0;
      trap_badv     <= '0;
      trap_badv_we  <= 1'b0;
      trap_era      <= '0;
      trap_era_we   <= 1'b0;
      store_state   <= 1'b0;
      restore_state <= 1'b0;
      flush         <= 1'b0;
      flush_pc      <= '0;
    end else begin
      trap_ecode    <= ECODE_W'(req.ecode);
      trap_ecode_we <= ~req.is_ertn;
      trap_badv     <= req.badv;
      trap_badv_we  <= req.badv_we;
      trap_era      <= req.era;
      trap_era_we   <= ~req.is_ertn;
      store_state   <= ~req.is_ertn;
      restore_state <= req.is_ertn;
      flush         <= 1'b1;
      flush_pc      <= req.is_ertn ? csr_era : csr_eentry;
    end
  end

endmodule

// File: tb/tb_csr_trap_sequencer.sv
// Directed plus random checks of the trap sequencer against
// a cycle-count reference model.
import csr_trap_pkg::*;

module tb_csr_trap_sequencer;

  localparam int DRAIN_CYC = 2;
  localparam int ECODE_INT = 0;

  logic        clk = 1'b0;
  logic        rstn, stall;
  logic        a_v, b_v, a_exc, b_exc;
  logic [6:0]  a_ec, b_ec;
  logic        a_bwe, b_bwe;
  logic [31:0] a_badv, b_badv, a_pc, b_pc;
  logic        b_ertn, int_req;
  logic [31:0] eentry, era_csr;

  logic        kill_b;
  logic [6:0]  trap_ecode;
  logic        trap_ecode_we;
  logic [31:0] trap_badv;
  logic        trap_badv_we;
  logic [31:0] trap_era;
  logic        trap_era_we;
  logic        store_state, restore_state, flush;
  logic [31:0] flush_pc;
  logic        int_pending, busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_flush = -100;
  int prev_flush = -100;

  // model: cycles until idle, and sticky interrupt
  int   m_cool = 0;
  logic m_pend = 1'b0;

  always #5 clk = ~clk;

  csr_trap_sequencer #(
    .ECODE_W   (7),
    .DRAIN_CYC (DRAIN_CYC),
    .ECODE_INT (ECODE_INT)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .stall         (stall),
    .mem_a_valid   (a_v),
    .mem_b_valid   (b_v),
    .mem_a_exc     (a_exc),
    .mem_b_exc     (b_exc),
    .mem_a_ecode   (a_ec),
    .mem_b_ecode   (b_ec),
    .mem_a_badv_we (a_bwe),
    .mem_b_badv_we (b_bwe),
    .mem_a_badv    (a_badv),
    .mem_b_badv    (b_badv),
    .mem_a_pc      (a_pc),
    .mem_b_pc      (b_pc),
    .mem_b_ertn    (b_ertn),
    .int_req       (int_req),
    .csr_eentry    (eentry),
    .csr_era       (era_csr),
    .kill_b        (kill_b),
    .trap_ecode    (trap_ecode),
    .trap_ecode_we (trap_ecode_we),
    .trap_badv     (trap_badv),
    .trap_badv_we  (trap_badv_we),
    .trap_era      (trap_era),
    .trap_era_we   (trap_era_we),
    .store_state   (store_state),
    .restore_state (restore_state),
    .flush         (flush),
    .flush_pc      (flush_pc),
    .int_pending   (int_pending),
    .busy          (busy)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h",
             tag, cyc, obs, exp);
    end
  endtask

  task automatic clr();
    stall = 0; a_v = 0; b_v = 0; a_exc = 0; b_exc = 0;
    a_ec = 0; b_ec = 0; a_bwe = 0; b_bwe = 0;
    a_badv = 0; b_badv = 0; b_ertn = 0; int_req = 0;
  endtask

  task automatic step();
    logic [6:0]  e_ec;
    logic [31:0] e_badv, e_era, e_pc;
    logic        e_ecwe, e_bwe, e_erawe, e_st, e_rs, e_fl;
    logic        ip, anyv, ek;
    int          n_cool;
    logic        n_pend;
    #1;
    ek = (m_cool == 0) && a_v && (a_exc || int_req || m_pend);
    chk("kill_b", kill_b, ek);
    e_ec = 0; e_badv = 0; e_era = 0; e_pc = 0;
    e_ecwe = 0; e_bwe = 0; e_erawe = 0;
    e_st = 0; e_rs = 0; e_fl = 0;
    ip = int_req | m_pend;
    anyv = a_v | b_v;
    n_cool = (m_cool > 0) ? m_cool - 1 : 0;
    n_pend = m_pend | int_req;
    if (!rstn) begin
      n_cool = 0;
      n_pend = 0;
    end else if (m_cool == 0 && !stall) begin
      if (ip && anyv) begin
        e_ec = 7'(ECODE_INT);
        e_era = a_v ? a_pc : b_pc;
        n_pend = 0;
      end else if (a_v && a_exc) begin
        e_ec = a_ec; e_badv = a_badv; e_bwe = a_bwe; e_era = a_pc;
      end else if (b_v && b_exc) begin
        e_ec = b_ec; e_badv = b_badv; e_bwe = b_bwe; e_era = b_pc;
      end else if (b_v && b_ertn) begin
        e_rs = 1; e_fl = 1; e_pc = era_csr;
        n_cool = 1 + DRAIN_CYC;
      end
      if ((ip && anyv) || (a_v && a_exc) || (b_v && b_exc)) begin
        e_ecwe = 1; e_erawe = 1; e_st = 1; e_fl = 1;
        e_pc = eentry;
        n_cool = 1 + DRAIN_CYC;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    m_cool = n_cool;
    m_pend = n_pend;
    if (flush) begin
      prev_flush = last_flush;
      last_flush = cyc;
    end
    chk("ecode", trap_ecode, e_ec);
    chk("ecode_we", trap_ecode_we, e_ecwe);
    chk("badv", trap_badv, e_badv);
    chk("badv_we", trap_badv_we, e_bwe);
    chk("era", trap_era, e_era);
    chk("era_we", trap_era_we, e_erawe);
    chk("store_state", store_state, e_st);
    chk("restore_state", restore_state, e_rs);
    chk("flush", flush, e_fl);
    chk("flush_pc", flush_pc, e_pc);
    chk("int_pending", int_pending, m_pend);
    chk("busy", busy, m_cool != 0);
  endtask

  task automatic idle_n(int n);
    clr();
    repeat (n) step();
  endtask

  initial begin
    clr();
    eentry = 32'h1C00_8000;
    era_csr = 32'h1C00_0200;
    a_pc = 32'h1C00_0100;
    b_pc = 32'h1C00_0104;
    rstn = 0;
    step();
    step();
    rstn = 1;
    step();

    // A syscall kills B, traps to eentry
    a_v = 1; a_exc = 1; a_ec = EC_SYS; b_v = 1;
    step();
    idle_n(4);

    // B address-misaligned with badv
    a_v = 1; b_v = 1; b_exc = 1; b_ec = EC_ALE;
    b_bwe = 1; b_badv = 32'h0000_0003;
    step();
    idle_n(4);

    // interrupt with no valid slot latches, taken later
    int_req = 1;
    step();
    idle_n(3);
    a_v = 1;
    step();
    idle_n(4);

    // interrupt during DRAIN of an ADEF trap
    a_v = 1; a_exc = 1; a_ec = EC_ADEF;
    a_bwe = 1; a_badv = a_pc;
    step();
    clr();
    step();
    a_v = 1; int_req = 1;
    step();
    int_req = 0;
    repeat (4) step();
    idle_n(4);
    chk("flush_gap", (last_flush - prev_flush) >= DRAIN_CYC + 1, 1);

    // ertn on B
    b_v = 1; b_ertn = 1;
    step();
    idle_n(4);

    // exception and interrupt together: interrupt wins
    a_v = 1; a_exc = 1; a_ec = EC_BRK; int_req = 1;
    step();
    idle_n(4);

    // stall holds off capture, reset during TRAP
    a_v = 1; a_exc = 1; a_ec = EC_INE; stall = 1;
    repeat (4) step();
    stall = 0;
    step();
    rstn = 0;
    step();
    rstn = 1; stall = 1;
    repeat (2) step();
    stall = 0;
    step();
    idle_n(4);

    // random traffic
    repeat (600) begin
      rstn    = ($urandom_range(0, 49) != 0);
      stall   = ($urandom_range(0, 4) == 0);
      a_v     = $urandom_range(0, 1) == 1;
      b_v     = $urandom_range(0, 1) == 1;
      a_exc   = ($urandom_range(0, 5) == 0);
      b_exc   = ($urandom_range(0, 5) == 0);
      b_ertn  = ($urandom_range(0, 5) == 0);
      int_req = ($urandom_range(0, 11) == 0);
      a_ec    = 7'($urandom_range(1, 127));
      b_ec    = 7'($urandom_range(1, 127));
      a_bwe   = $urandom_range(0, 1) == 1;
      b_bwe   = $urandom_range(0, 1) == 1;
      a_badv  = $urandom;
      b_badv  = $urandom;
      a_pc    = {$urandom} & 32'hFFFF_FFFC;
      b_pc    = a_pc + 32'd4;
      eentry  = {$urandom} & 32'hFFFF_FFC0;
      era_csr = $urandom;
      step();
    end
    rstn = 1;
    idle_n(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
